// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, constants and round-robin picker for bus_arbiter
//
// Contents:
//   arb_state_t         arbiter state encoding
//   OWNER_CPU           OWNER value while the 68030 owns the bus
//   DEFAULT_BG_TIMEOUT  cycles a granted master has to answer with BGACK
//   MAX_REQ             widest requester vector the picker handles
//   rr_pick()           round-robin winner selection
package bus_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CPU,
        ST_GRANT,
        ST_OWNED,
        ST_NEXT,
        ST_RELEASE
    } arb_state_t;

    localparam int OWNER_CPU          = 0;
    localparam int DEFAULT_BG_TIMEOUT = 64;
    localparam int MAX_REQ            = 4;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rr_pick_t;

    // req is active-high. Scans ptr, ptr+1, ... modulo nreq and returns the
    // first set bit. The loop runs from the far end downwards so that the
    // candidate closest to ptr is the last one written and therefore wins.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [1:0]         ptr,
        input int                 nreq
    );
        rr_pick_t   r;
        logic [1:0] j;
        r.valid = 1'b0;
        r.idx   = 2'd0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < nreq) begin
                j = 2'((int'(ptr) + i) % nreq);
                if (req[j]) begin
                    r.valid = 1'b1;
                    r.idx   = j;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for active-low asynchronous inputs
//
// Ports:
//   CLKCPU  destination clock
//   RESET   asynchronous active-high reset; both stages reset to 1 (inactive)
//   d       asynchronous input vector
//   q       synchronised output, two CLKCPU cycles behind d
module sync2 #(
    parameter int W = 1
) (
    input  logic         CLKCPU,
    input  logic         RESET,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 68000 BR/BG/BGACK arbiter between the 68030 and external bus masters
//
// Ports:
//   CLKCPU  accelerator clock, the only clock
//   RESET   asynchronous active-high reset
//   BR      active-low requests from external masters (asynchronous)
//   BGACK   active-low bus grant acknowledge (asynchronous)
//   AS      active-low Amiga address strobe (asynchronous)
//   AS20    active-low 68030 address strobe
//   BG20    active-low bus grant from the 68030
//   BR20    active-low bus request to the 68030
//   BG      active-low per-requester grant, at most one bit low
//   OWNER   bus owner: 0 = CPU, i+1 = requester i
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int BG_TIMEOUT = DEFAULT_BG_TIMEOUT,
    parameter int OWNER_W    = 3
) (
    input  logic               CLKCPU,
    input  logic               RESET,
    input  logic [NREQ-1:0]    BR,
    input  logic               BGACK,
    input  logic               AS,
    input  logic               AS20,
    input  logic               BG20,
    output logic               BR20,
    output logic [NREQ-1:0]    BG,
    output logic [OWNER_W-1:0] OWNER
);

    localparam int CNT_W = $clog2(BG_TIMEOUT) + 1;

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic [NREQ-1:0] br_s;
    logic            bgack_s;
    logic            as_s;

    sync2 #(.W(NREQ)) u_sync_br (
        .CLKCPU (CLKCPU),
        .RESET  (RESET),
        .d      (BR),
        .q      (br_s)
    );

    sync2 #(.W(1)) u_sync_bgack (
        .CLKCPU (CLKCPU),
        .RESET  (RESET),
        .d      (BGACK),
        .q      (bgack_s)
    );

    sync2 #(.W(1)) u_sync_as (
        .CLKCPU (CLKCPU),
        .RESET  (RESET),
        .d      (AS),
        .q      (as_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t         state, state_d;
    logic [1:0]         winner, winner_d;
    logic [1:0]         rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic [MAX_REQ-1:0] req_all;
    logic [MAX_REQ-1:0] req_oth;
    rr_pick_t           pick_all;
    rr_pick_t           pick_oth;
    logic               bus_free;
    logic               win_req;
    logic               timed_out;

    logic               br20_d;
    logic [NREQ-1:0]    bg_d;
    logic [OWNER_W-1:0] owner_d;

    function automatic logic [1:0] ptr_after(input logic [1:0] idx);
        return (idx == 2'(NREQ - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    // Active-high request views: everyone, and everyone except the current
    // winner (used when handing the bus on without returning it to the CPU).
    always_comb begin
        req_all             = '0;
        req_all[NREQ-1:0]   = ~br_s;
        req_oth             = req_all;
        req_oth[winner]     = 1'b0;
    end

    assign pick_all  = rr_pick(req_all, rr_ptr, NREQ);
    assign pick_oth  = rr_pick(req_oth, rr_ptr, NREQ);
    assign win_req   = req_all[winner];
    assign timed_out = (cnt == CNT_W'(BG_TIMEOUT - 1));

    // The 68030 has let go only once it grants, its own strobe is idle, the
    // Amiga side strobe is idle and no other master still holds BGACK.
    assign bus_free  = !BG20 && AS20 && as_s && bgack_s;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state;
        winner_d = winner;
        rr_ptr_d = rr_ptr;
        cnt_d    = cnt;

        case (state)
            ST_IDLE: begin
                // An unsolicited master holding BGACK keeps us from asking.
                if (pick_all.valid && bgack_s) begin
                    winner_d = pick_all.idx;
                    state_d  = ST_WAIT_CPU;
                end
            end

            ST_WAIT_CPU: begin
                if (!win_req) begin
                    if (pick_oth.valid) begin
                        winner_d = pick_oth.idx;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else if (bus_free) begin
                    state_d  = ST_GRANT;
                    cnt_d    = '0;
                    rr_ptr_d = ptr_after(winner);
                end
            end

            ST_GRANT: begin
                cnt_d = cnt + CNT_W'(1);
                // BGACK takes priority over withdrawal and timeout.
                if (!bgack_s) begin
                    state_d = ST_OWNED;
                end else if (!win_req || timed_out) begin
                    state_d = ST_NEXT;
                end
            end

            ST_OWNED: begin
                // BGACKs was low on entry, so the first high is the release.
                if (bgack_s) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                // Hand straight over to another waiting master; the 68030
                // still has the bus granted to us, so BR20 stays low.
                if (pick_oth.valid) begin
                    winner_d = pick_oth.idx;
                    state_d  = ST_GRANT;
                    cnt_d    = '0;
                    rr_ptr_d = ptr_after(pick_oth.idx);
                end else begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so outputs are registered and
    // change on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        br20_d = !(state_d inside {ST_WAIT_CPU, ST_GRANT, ST_OWNED, ST_NEXT});

        bg_d = '1;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_d == ST_GRANT) && (winner_d == 2'(i))) begin
                bg_d[i] = 1'b0;
            end
        end

        if (state_d inside {ST_GRANT, ST_OWNED, ST_NEXT}) begin
            owner_d = OWNER_W'(winner_d) + OWNER_W'(1);
        end else begin
            owner_d = OWNER_W'(OWNER_CPU);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            winner <= 2'd0;
            rr_ptr <= 2'd0;
            cnt    <= '0;
            BR20   <= 1'b1;
            BG     <= '1;
            OWNER  <= OWNER_W'(OWNER_CPU);
        end else begin
            state  <= state_d;
            winner <= winner_d;
            rr_ptr <= rr_ptr_d;
            cnt    <= cnt_d;
            BR20   <= br20_d;
            BG     <= bg_d;
            OWNER  <= owner_d;
        end
    end

endmodule
